// File: rtl/raisin64_sim_ctrl_pkg.sv
// rtl/raisin64_sim_ctrl_pkg.sv - shared state encodings and mailbox defaults for the sim controller
package raisin64_sim_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_SEQ  = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } sim_state_t;

  // Software link scripts place the mailbox here; benches use the same values.
  localparam logic [63:0] DEF_MBOX_ADDR = 64'hFFF0;
  localparam logic [63:0] DEF_PASS_CODE = 64'h1;

  // Sequence-counter value at which channel ch releases on the following edge.
  function automatic int rst_release_cnt(input int hold, input int stagger, input int ch);
    return hold + ch * stagger;
  endfunction

endpackage

// File: rtl/raisin64_sim_ctrl_if.sv
// rtl/raisin64_sim_ctrl_if.sv - data-memory write bus snooped for the mailbox
interface raisin64_sim_ctrl_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              mbox_we;
  logic [ADDR_W-1:0] mbox_addr;
  logic [DATA_W-1:0] mbox_wdata;

  modport master (output mbox_we, output mbox_addr, output mbox_wdata);
  modport slave  (input  mbox_we, input  mbox_addr, input  mbox_wdata);
endinterface

// File: rtl/raisin64_rst_stagger.sv
// rtl/raisin64_rst_stagger.sv - staggered release of sub-reset channels after board reset
module raisin64_rst_stagger
  import raisin64_sim_ctrl_pkg::*;
#(
  parameter int NUM_RST     = 2,
  parameter int RST_HOLD    = 2,
  parameter int RST_STAGGER = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [NUM_RST-1:0] sub_rst_n,
  output logic               all_released
);

  localparam int LAST  = rst_release_cnt(RST_HOLD, RST_STAGGER, NUM_RST - 1);
  localparam int SEQ_W = $clog2(LAST + 2);

  logic [SEQ_W-1:0] seq_cnt;

  // Counter parks at the last release point so it never wraps and re-triggers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq_cnt <= '0;
    end else if (seq_cnt != SEQ_W'(LAST)) begin
      seq_cnt <= seq_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_rst_n <= '0;
    end else begin
      for (int i = 0; i < NUM_RST; i++) begin
        if (seq_cnt >= SEQ_W'(rst_release_cnt(RST_HOLD, RST_STAGGER, i))) begin
          sub_rst_n[i] <= 1'b1;
        end
      end
    end
  end

  assign all_released = &sub_rst_n;

endmodule

// File: rtl/raisin64_sim_ctrl.sv
// rtl/raisin64_sim_ctrl.sv - bring-up controller: reset sequencing, run counting, mailbox pass/fail
module raisin64_sim_ctrl
  import raisin64_sim_ctrl_pkg::*;
#(
  parameter int          NUM_RST     = 2,
  parameter int          RST_HOLD    = 2,
  parameter int          RST_STAGGER = 1,
  parameter int          TIMEOUT     = 100,
  parameter int          ADDR_W      = 64,
  parameter int          DATA_W      = 64,
  parameter int          CNT_W       = 32,
  parameter logic [63:0] MBOX_ADDR   = DEF_MBOX_ADDR,
  parameter logic [63:0] PASS_CODE   = DEF_PASS_CODE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  raisin64_sim_ctrl_if.slave   mbox,
  output logic [NUM_RST-1:0]   sub_rst_n,
  output logic                 run,
  output logic [CNT_W-1:0]     cycle_cnt,
  output logic                 done,
  output logic                 pass,
  output logic                 fail,
  output logic                 timeout,
  output logic [DATA_W-1:0]    result
);

  localparam logic [ADDR_W-1:0] MBOX_A  = ADDR_W'(MBOX_ADDR);
  localparam logic [DATA_W-1:0] PASS_D  = DATA_W'(PASS_CODE);
  localparam logic [CNT_W-1:0]  TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam bit                TO_EN   = (TIMEOUT != 0);

  sim_state_t state;
  logic       all_released;
  logic       mbox_hit;
  logic       to_hit;
  logic       is_pass;

  raisin64_rst_stagger #(
    .NUM_RST     (NUM_RST),
    .RST_HOLD    (RST_HOLD),
    .RST_STAGGER (RST_STAGGER)
  ) u_rst_stagger (
    .clk          (clk),
    .rst_n        (rst_n),
    .sub_rst_n    (sub_rst_n),
    .all_released (all_released)
  );

  assign mbox_hit = mbox.mbox_we && (mbox.mbox_addr == MBOX_A);
  assign to_hit   = TO_EN && (cycle_cnt == TO_LAST);
  assign is_pass  = (mbox.mbox_wdata == PASS_D);

  // A mailbox hit on the timeout edge takes priority so a late pass is not lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_SEQ;
      run       <= 1'b0;
      cycle_cnt <= '0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail      <= 1'b0;
      timeout   <= 1'b0;
      result    <= '0;
    end else begin
      case (state)
        ST_SEQ: begin
          if (all_released) begin
            state <= ST_RUN;
            run   <= 1'b1;
          end
        end
        ST_RUN: begin
          if (cycle_cnt != '1) begin
            cycle_cnt <= cycle_cnt + 1'b1;
          end
          if (mbox_hit) begin
            state  <= ST_DONE;
            run    <= 1'b0;
            done   <= 1'b1;
            result <= mbox.mbox_wdata;
            pass   <= is_pass;
            fail   <= !is_pass;
          end else if (to_hit) begin
            state   <= ST_DONE;
            run     <= 1'b0;
            done    <= 1'b1;
            fail    <= 1'b1;
            timeout <= 1'b1;
          end
        end
        default: begin
          state <= ST_DONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_raisin64_sim_ctrl.sv
// tb/tb_raisin64_sim_ctrl.sv - directed self-checking bench for raisin64_sim_ctrl
module tb_raisin64_sim_ctrl;
  import raisin64_sim_ctrl_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1, rst2;
  int checks = 0;
  int errors = 0;

  raisin64_sim_ctrl_if #(.ADDR_W(64), .DATA_W(64)) m0 ();
  raisin64_sim_ctrl_if #(.ADDR_W(64), .DATA_W(64)) m1 ();
  raisin64_sim_ctrl_if #(.ADDR_W(64), .DATA_W(64)) m2 ();

  logic [1:0]  sr0, sr1;
  logic [3:0]  sr2;
  logic        run0, done0, pass0, fail0, to0;
  logic        run1, done1, pass1, fail1, to1;
  logic        run2, done2, pass2, fail2, to2;
  logic [31:0] cnt0, cnt1, cnt2;
  logic [63:0] res0, res1, res2;

  raisin64_sim_ctrl dut0 (
    .clk(clk), .rst_n(rst0), .mbox(m0.slave), .sub_rst_n(sr0), .run(run0), .cycle_cnt(cnt0),
    .done(done0), .pass(pass0), .fail(fail0), .timeout(to0), .result(res0)
  );

  raisin64_sim_ctrl #(.TIMEOUT(0)) dut1 (
    .clk(clk), .rst_n(rst1), .mbox(m1.slave), .sub_rst_n(sr1), .run(run1), .cycle_cnt(cnt1),
    .done(done1), .pass(pass1), .fail(fail1), .timeout(to1), .result(res1)
  );

  raisin64_sim_ctrl #(.NUM_RST(4), .RST_STAGGER(3)) dut2 (
    .clk(clk), .rst_n(rst2), .mbox(m2.slave), .sub_rst_n(sr2), .run(run2), .cycle_cnt(cnt2),
    .done(done2), .pass(pass2), .fail(fail2), .timeout(to2), .result(res2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic release0();
    rst0 = 1'b0;
    repeat (2) @(negedge clk);
    rst0 = 1'b1;
  endtask

  task automatic write0(input logic [63:0] a, input logic [63:0] d);
    m0.mbox_we = 1'b1; m0.mbox_addr = a; m0.mbox_wdata = d;
    tick();
    m0.mbox_we = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    checks++;
    if ({sr0, run0, done0, pass0, fail0, to0} !== 7'b0) begin
      errors++; $display("FAIL reset_flags: got %b exp 0", {sr0, run0, done0, pass0, fail0, to0});
    end
    checks++;
    if (cnt0 !== 32'd0) begin errors++; $display("FAIL reset_cnt: got %0d exp 0", cnt0); end
    checks++;
    if (res0 !== 64'd0) begin errors++; $display("FAIL reset_result: got %h exp 0", res0); end
  endtask

  task automatic test_seq_release();
    logic [1:0] exp_sr [4];
    exp_sr = '{2'b00, 2'b00, 2'b01, 2'b11};
    m0.mbox_we = 1'b1; m0.mbox_addr = 64'hFFF0; m0.mbox_wdata = 64'h1;
    @(negedge clk);
    rst0 = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      tick();
      checks++;
      if (sr0 !== exp_sr[e-1] || run0 !== 1'b0) begin
        errors++; $display("FAIL seq_edge%0d: got sr=%b run=%b exp sr=%b run=0", e, sr0, run0, exp_sr[e-1]);
      end
    end
    m0.mbox_we = 1'b0;
    tick();
    checks++;
    if (run0 !== 1'b1 || cnt0 !== 32'd0 || done0 !== 1'b0) begin
      errors++; $display("FAIL run_start: got run=%b cnt=%0d done=%b exp 1,0,0", run0, cnt0, done0);
    end
  endtask

  task automatic test_pass();
    for (int i = 1; i <= 20; i++) begin
      if (i == 10) write0(64'hFFF8, 64'h1);
      else tick();
    end
    checks++;
    if (cnt0 !== 32'd20 || done0 !== 1'b0) begin
      errors++; $display("FAIL pass_pre: got cnt=%0d done=%b exp 20,0", cnt0, done0);
    end
    write0(64'hFFF0, 64'h1);
    checks++;
    if ({done0, pass0, fail0, to0, run0} !== 5'b11000 || res0 !== 64'h1 || cnt0 !== 32'd21) begin
      errors++; $display("FAIL pass_hit: got dpftr=%b res=%h cnt=%0d exp 11000,1,21",
                         {done0, pass0, fail0, to0, run0}, res0, cnt0);
    end
    repeat (3) tick();
    checks++;
    if (cnt0 !== 32'd21 || done0 !== 1'b1) begin
      errors++; $display("FAIL pass_frozen: got cnt=%0d done=%b exp 21,1", cnt0, done0);
    end
  endtask

  task automatic test_fail_then_ignore();
    release0();
    repeat (5) tick();
    write0(64'hFFF0, 64'hDEAD);
    checks++;
    if ({done0, pass0, fail0, to0, run0} !== 5'b10100 || res0 !== 64'hDEAD) begin
      errors++; $display("FAIL fail_hit: got dpftr=%b res=%h exp 10100,dead", {done0, pass0, fail0, to0, run0}, res0);
    end
    write0(64'hFFF0, 64'h1);
    tick();
    checks++;
    if ({done0, pass0, fail0, to0, run0} !== 5'b10100 || res0 !== 64'hDEAD || cnt0 !== 32'd1) begin
      errors++; $display("FAIL done_ignore: got dpftr=%b res=%h cnt=%0d exp 10100,dead,1",
                         {done0, pass0, fail0, to0, run0}, res0, cnt0);
    end
  endtask

  task automatic test_timeout();
    release0();
    repeat (5) tick();
    repeat (99) tick();
    checks++;
    if (cnt0 !== 32'd99 || done0 !== 1'b0) begin
      errors++; $display("FAIL timeout_pre: got cnt=%0d done=%b exp 99,0", cnt0, done0);
    end
    tick();
    checks++;
    if ({done0, pass0, fail0, to0, run0} !== 5'b10110 || res0 !== 64'd0 || cnt0 !== 32'd100) begin
      errors++; $display("FAIL timeout_fire: got dpftr=%b res=%h cnt=%0d exp 10110,0,100",
                         {done0, pass0, fail0, to0, run0}, res0, cnt0);
    end
  endtask

  task automatic test_hit_on_timeout();
    release0();
    repeat (104) tick();
    write0(64'hFFF0, 64'h1);
    checks++;
    if ({done0, pass0, fail0, to0, run0} !== 5'b11000 || res0 !== 64'h1) begin
      errors++; $display("FAIL hit_vs_timeout: got dpftr=%b res=%h exp 11000,1", {done0, pass0, fail0, to0, run0}, res0);
    end
  endtask

  task automatic test_no_timeout();
    @(negedge clk);
    rst1 = 1'b1;
    repeat (1005) tick();
    checks++;
    if (done1 !== 1'b0 || run1 !== 1'b1 || cnt1 !== 32'd1000 || to1 !== 1'b0) begin
      errors++; $display("FAIL no_timeout: got done=%b run=%b cnt=%0d to=%b exp 0,1,1000,0", done1, run1, cnt1, to1);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    rst2 = 1'b1;
    repeat (7) tick();
    checks++;
    if (sr2 !== 4'b0011) begin errors++; $display("FAIL seq4_mid: got %b exp 0011", sr2); end
    #2 rst2 = 1'b0;
    #1;
    checks++;
    if ({sr2, run2} !== 5'b0) begin errors++; $display("FAIL async_seq: got sr=%b run=%b exp 0", sr2, run2); end
    @(negedge clk);
    rst2 = 1'b1;
    for (int e = 1; e <= 13; e++) begin
      tick();
      if (e == 11) begin
        checks++;
        if (sr2 !== 4'b0111) begin errors++; $display("FAIL seq4_e11: got %b exp 0111", sr2); end
      end
      if (e == 12) begin
        checks++;
        if (sr2 !== 4'b1111 || run2 !== 1'b0) begin
          errors++; $display("FAIL seq4_e12: got sr=%b run=%b exp 1111,0", sr2, run2);
        end
      end
    end
    checks++;
    if (run2 !== 1'b1 || cnt2 !== 32'd0) begin
      errors++; $display("FAIL seq4_run: got run=%b cnt=%0d exp 1,0", run2, cnt2);
    end
    repeat (5) tick();
    #2 rst2 = 1'b0;
    #1;
    checks++;
    if ({sr2, run2} !== 5'b0 || cnt2 !== 32'd0) begin
      errors++; $display("FAIL async_run: got sr=%b run=%b cnt=%0d exp 0", sr2, run2, cnt2);
    end
    @(negedge clk);
    rst2 = 1'b1;
    repeat (13) tick();
    m2.mbox_we = 1'b1; m2.mbox_addr = 64'hFFF0; m2.mbox_wdata = 64'hBAD;
    tick();
    m2.mbox_we = 1'b0;
    checks++;
    if ({done2, fail2} !== 2'b11 || res2 !== 64'hBAD) begin
      errors++; $display("FAIL seq4_fail: got done=%b fail=%b res=%h exp 1,1,bad", done2, fail2, res2);
    end
    #2 rst2 = 1'b0;
    #1;
    checks++;
    if ({sr2, done2, pass2, fail2, to2} !== 8'b0 || res2 !== 64'd0) begin
      errors++; $display("FAIL async_done: got flags=%b res=%h exp 0", {sr2, done2, pass2, fail2, to2}, res2);
    end
  endtask

  initial begin
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    m0.mbox_we = 1'b0; m0.mbox_addr = '0; m0.mbox_wdata = '0;
    m1.mbox_we = 1'b0; m1.mbox_addr = '0; m1.mbox_wdata = '0;
    m2.mbox_we = 1'b0; m2.mbox_addr = '0; m2.mbox_wdata = '0;
    test_reset();
    test_seq_release();
    test_pass();
    test_fail_then_ignore();
    test_timeout();
    test_hit_on_timeout();
    test_no_timeout();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/raisin64_sim_ctrl.md
Name: raisin64_sim_ctrl

Overview:
Synthesizable simulation/bring-up controller that replaces the hand-coded reset and timeout sequencing in top-level benches.
- Reset sequencing: takes the single board reset and releases a parametrised number of sub-reset channels in a staggered order (e.g. memories before core).
- Run-cycle counting: counts cycles while the design runs.
- Pass/fail detection: snoops the data-memory write bus for a mailbox write and reports pass/fail/timeout as sticky flags, so benches and FPGA builds share one termination mechanism.

Parameters:
- NUM_RST, 2: number of sub-reset channels (≥1).
- RST_HOLD, 2: cycles after rst_n release before channel 0 releases.
- RST_STAGGER, 1: cycles between successive channel releases (0 = release all together).
- TIMEOUT, 100: RUN cycles before timeout; 0 disables timeout.
- ADDR_W, 64: mailbox address width.
- DATA_W, 64: mailbox data width.
- CNT_W, 32: cycle counter width.
- MBOX_ADDR, 64'hFFF0: mailbox byte address (truncated to ADDR_W).
- PASS_CODE, 64'h1: data value meaning pass (truncated to DATA_W).

Ports:
- clk, in, 1: system clock, rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- mbox_we, in, 1: data-memory write strobe.
- mbox_addr, in, ADDR_W: data-memory write address.
- mbox_wdata, in, DATA_W: data-memory write data.
- sub_rst_n, out, NUM_RST: staggered active-low resets to sub-blocks.
- run, out, 1: all channels released, test in progress.
- cycle_cnt, out, CNT_W: RUN cycles elapsed.
- done, out, 1: test terminated (sticky).
- pass, out, 1: mailbox held PASS_CODE (sticky).
- fail, out, 1: mailbox held other value, or timeout (sticky).
- timeout, out, 1: terminated by TIMEOUT (sticky).
- result, out, DATA_W: captured mailbox data.

Behaviour:
- Reset is asynchronous and active-low on rst_n, single clock clk. While rst_n=0:
  - sub_rst_n=0 (all bits); run, done, pass, fail and timeout = 0; cycle_cnt=0; result=0.
  - State = SEQ; sequence counter = 0.
- All outputs are registered.
- States: SEQ -> RUN -> DONE.
- SEQ:
  - Sequence counter increments every edge.
  - sub_rst_n[i] rises on rising edge number RST_HOLD + i*RST_STAGGER + 1 after rst_n deassertion. Example: defaults give ch0 on edge 3, ch1 on edge 4.
  - Once set, sub_rst_n[i] stays 1 until rst_n falls.
  - On the edge after the last channel releases, go to RUN and set run=1.
- RUN:
  - cycle_cnt increments each edge, saturating at all-ones; it reads 0 in the first RUN cycle.
  - Mailbox hit: mbox_we=1 and mbox_addr==MBOX_ADDR, sampled at an edge. Result: result<=mbox_wdata, done<=1, pass<=(wdata==PASS_CODE), fail<=!pass, run<=0, state DONE.
  - Timeout: TIMEOUT≠0 and cycle_cnt==TIMEOUT-1 with no hit at that edge. Result: done=1, fail=1, timeout=1, run=0, state DONE; result unchanged (0).
  - Mailbox hit and timeout on the same edge: the mailbox hit wins and timeout stays 0.
- DONE:
  - All flags, result and cycle_cnt are frozen.
  - sub_rst_n stays all-1; the core is not re-reset.
  - Further mailbox writes are ignored.
- Writes in SEQ, or to non-matching addresses, are ignored.
- rst_n assertion in any state returns everything to reset values immediately (asynchronously). Deassertion restarts the sequence from edge 1.
- Invariants:
  - pass and fail are never both 1.
  - done=1 iff pass|fail.
  - run and done are never both 1.

Decomposition:
- Shared header raisin64_sim_defs.vh holds:
  - state encodings (SEQ=2'd0, RUN=2'd1, DONE=2'd2);
  - default MBOX_ADDR and PASS_CODE constants, so software link scripts and benches agree.
- One sub-module, raisin64_rst_stagger: parametrised by NUM_RST, RST_HOLD and RST_STAGGER. Owns the sequence counter and sub_rst_n, and outputs all_released.
- raisin64_sim_ctrl holds the RUN/DONE FSM, cycle counter and mailbox compare.

Test Plan:
- Defaults, release rst_n after 15 ns on 10 ns clock -> sub_rst_n = 2'b00, 2'b00, 2'b01, 2'b11 on edges 1–4; run=1 from edge 5; cycle_cnt=0 in the first RUN cycle.
- RUN, write addr 0xFFF0 data 0x1 at cycle_cnt=20 -> done=1, pass=1, fail=0, result=0x1, cycle_cnt frozen at 21, run=0.
- Write 0xFFF0 data 0xDEAD -> fail=1, pass=0, result=0xDEAD. A later write of 0x1 leaves all outputs unchanged.
- No writes, TIMEOUT=100 -> on the edge where cycle_cnt=99: done=1, fail=1, timeout=1, result=0. With TIMEOUT=0 and no writes over 1000 cycles -> done stays 0.
- Hit on the exact timeout edge -> pass=1, timeout=0. Writes to 0xFFF8 or during SEQ -> no effect.
- Assert rst_n mid-RUN and mid-SEQ (NUM_RST=4, RST_STAGGER=3) -> all outputs 0 immediately without a clock edge. On re-release, channel 3 rises on edge 12.
